// File: rtl/reg_scoreboard_pkg.sv
// Shared CPU register-file constants and helpers used by the issue scoreboard.
package reg_scoreboard_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int CNT_W      = 3;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] idx);
    reg_onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Register scoreboard: tracks long-latency destination writes and stalls
// decode on RAW/WAW hazards or when too many long writes are in flight.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  issue_valid_i,
  input  logic [REG_ADDR_W-1:0] issue_rs1_i,
  input  logic [REG_ADDR_W-1:0] issue_rs2_i,
  input  logic                  issue_use_rs1_i,
  input  logic                  issue_use_rs2_i,
  input  logic [REG_ADDR_W-1:0] issue_rd_i,
  input  logic                  issue_long_i,
  input  logic                  flush_i,
  input  logic                  wb_valid_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  output logic                  stall_o,
  output logic [NUM_REGS-1:0]   pending_o,
  output logic [CNT_W-1:0]      outstanding_o,
  output logic                  err_o
);

  localparam logic [CNT_W:0]      MAX_CNT  = (CNT_W+1)'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0]    CNT_TOP  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [REG_ADDR_W-1:0] REG_X0 = {REG_ADDR_W{1'b0}};

  logic [NUM_REGS-1:0] pending_r;
  logic [CNT_W-1:0]    outstanding_r;
  logic                err_r;

  logic [NUM_REGS-1:0] eff_pend_s;
  logic [CNT_W:0]      cnt_less_wb_s;
  logic                raw_s;
  logic                waw_s;
  logic                full_s;
  logic                stall_s;
  logic                accept_s;
  logic                retire_s;
  logic                wb_bad_s;
  logic [NUM_REGS-1:0] pending_nxt_s;
  logic [CNT_W-1:0]    outstanding_nxt_s;
  logic                err_nxt_s;

  // Hazard detection; a same-cycle retire is masked out so it unblocks at once.
  always_comb begin
    eff_pend_s    = pending_r;
    cnt_less_wb_s = {1'b0, outstanding_r};
    raw_s         = 1'b0;
    waw_s         = 1'b0;
    full_s        = 1'b0;
    stall_s       = 1'b0;
    if (wb_valid_i) begin
      eff_pend_s    = pending_r & ~reg_onehot(wb_rd_i);
      cnt_less_wb_s = {1'b0, outstanding_r} - {{CNT_W{1'b0}}, 1'b1};
    end else begin
      eff_pend_s    = pending_r;
      cnt_less_wb_s = {1'b0, outstanding_r};
    end
    raw_s = (issue_use_rs1_i & eff_pend_s[issue_rs1_i]) |
            (issue_use_rs2_i & eff_pend_s[issue_rs2_i]);
    waw_s = issue_long_i & eff_pend_s[issue_rd_i];
    // x0 never occupies a slot, so it cannot be held back by the limit
    full_s = issue_long_i & (issue_rd_i != REG_X0) & (cnt_less_wb_s >= MAX_CNT);
    if (issue_valid_i && !flush_i) begin
      stall_s = raw_s | waw_s | full_s;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Next-state: set wins over clear on the same register; count saturates.
  always_comb begin
    accept_s          = 1'b0;
    retire_s          = 1'b0;
    wb_bad_s          = 1'b0;
    pending_nxt_s     = pending_r;
    outstanding_nxt_s = outstanding_r;
    err_nxt_s         = err_r;
    accept_s = issue_valid_i & ~flush_i & ~stall_s & issue_long_i & (issue_rd_i != REG_X0);
    retire_s = wb_valid_i & pending_r[wb_rd_i];
    wb_bad_s = wb_valid_i & (~pending_r[wb_rd_i] | (wb_rd_i == REG_X0));
    if (retire_s) begin
      pending_nxt_s = pending_nxt_s & ~reg_onehot(wb_rd_i);
    end else begin
      pending_nxt_s = pending_r;
    end
    if (accept_s) begin
      pending_nxt_s = pending_nxt_s | reg_onehot(issue_rd_i);
    end else begin
      pending_nxt_s = pending_nxt_s;
    end
    pending_nxt_s[0] = 1'b0;
    case ({accept_s, retire_s})
      2'b10: begin
        if (outstanding_r != CNT_TOP) begin
          outstanding_nxt_s = outstanding_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          outstanding_nxt_s = outstanding_r;
        end
      end
      2'b01: begin
        if (outstanding_r != CNT_ZERO) begin
          outstanding_nxt_s = outstanding_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          outstanding_nxt_s = outstanding_r;
        end
      end
      default: outstanding_nxt_s = outstanding_r;
    endcase
    if (wb_bad_s) begin
      err_nxt_s = 1'b1;
    end else begin
      err_nxt_s = err_r;
    end
  end

  // State registers; reset discards every in-flight entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_r     <= {NUM_REGS{1'b0}};
      outstanding_r <= CNT_ZERO;
      err_r         <= 1'b0;
    end else begin
      pending_r     <= pending_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      err_r         <= err_nxt_s;
    end
  end

  assign stall_o       = stall_s;
  assign pending_o     = pending_r;
  assign outstanding_o = outstanding_r;
  assign err_o         = err_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench: directed hazard scenarios plus randomized traffic
// compared against a set-based reference model of the scoreboard rules.
module tb_reg_scoreboard;

  localparam int MAX_A = 4;
  localparam int MAX_B = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        iv = 1'b0, u1 = 1'b0, u2 = 1'b0, lng = 1'b0, fl = 1'b0, wbv = 1'b0;
  logic [4:0]  rs1 = 5'd0, rs2 = 5'd0, rd = 5'd0, wbrd = 5'd0;
  logic        stall;
  logic [31:0] pend;
  logic [2:0]  outst;
  logic        err;

  logic        b_iv = 1'b0, b_lng = 1'b0;
  logic [4:0]  b_rd = 5'd0;
  logic        b_stall;
  logic [31:0] b_pend;
  logic [2:0]  b_outst;
  logic        b_err;

  reg_scoreboard #(.MAX_OUTSTANDING(MAX_A)) dut (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(iv), .issue_rs1_i(rs1), .issue_rs2_i(rs2),
    .issue_use_rs1_i(u1), .issue_use_rs2_i(u2), .issue_rd_i(rd), .issue_long_i(lng),
    .flush_i(fl), .wb_valid_i(wbv), .wb_rd_i(wbrd), .stall_o(stall), .pending_o(pend),
    .outstanding_o(outst), .err_o(err));

  reg_scoreboard #(.MAX_OUTSTANDING(MAX_B)) dut_b (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(b_iv), .issue_rs1_i(5'd0), .issue_rs2_i(5'd0),
    .issue_use_rs1_i(1'b0), .issue_use_rs2_i(1'b0), .issue_rd_i(b_rd), .issue_long_i(b_lng),
    .flush_i(1'b0), .wb_valid_i(1'b0), .wb_rd_i(5'd0), .stall_o(b_stall), .pending_o(b_pend),
    .outstanding_o(b_outst), .err_o(b_err));

  int tests_run = 0;
  int tests_failed = 0;

  // reference model: the set of registers awaiting a long write, plus the error flag
  bit m_pend [32];
  bit m_err;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  function automatic logic [31:0] m_vec();
    logic [31:0] v = 32'd0;
    for (int i = 0; i < 32; i++) v[i] = m_pend[i];
    return v;
  endfunction

  function automatic bit m_blocked(input logic [4:0] r, input bit wv, input logic [4:0] wr);
    return m_pend[r] && !(wv && (wr == r));
  endfunction

  function automatic bit m_stall(input bit v, input bit a1, input logic [4:0] s1, input bit a2,
                                 input logic [4:0] s2, input logic [4:0] d, input bit lo,
                                 input bit f, input bit wv, input logic [4:0] wr);
    bit hazard;
    if (!v || f) return 1'b0;
    hazard = (a1 && m_blocked(s1, wv, wr)) || (a2 && m_blocked(s2, wv, wr)) ||
             (lo && m_blocked(d, wv, wr)) ||
             (lo && d != 5'd0 && (m_count() - (wv ? 1 : 0)) >= MAX_A);
    return hazard;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
    m_err = 1'b0;
  endtask

  // one clock of stimulus on the main DUT, checked against the model
  task automatic step(input bit v, input logic [4:0] s1, input bit a1, input logic [4:0] s2,
                      input bit a2, input logic [4:0] d, input bit lo, input bit f,
                      input bit wv, input logic [4:0] wr, output logic st);
    bit exp_st, acc, ret;
    @(negedge clk);
    iv = v; rs1 = s1; u1 = a1; rs2 = s2; u2 = a2; rd = d; lng = lo; fl = f; wbv = wv; wbrd = wr;
    #1;
    exp_st = m_stall(v, a1, s1, a2, s2, d, lo, f, wv, wr);
    check_val("stall", {31'd0, stall}, {31'd0, exp_st});
    st = stall;
    acc = v && !f && !exp_st && lo && (d != 5'd0);
    ret = wv && m_pend[wr];
    if (wv && (!m_pend[wr] || wr == 5'd0)) m_err = 1'b1;
    if (ret) m_pend[wr] = 1'b0;
    if (acc) m_pend[d] = 1'b1;
    @(posedge clk);
    #1;
    check_val("pending", pend, m_vec());
    check_val("outstanding", {29'd0, outst}, m_count());
    check_val("err", {31'd0, err}, {31'd0, m_err});
  endtask

  task automatic idle();
    logic st;
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, st);
  endtask

  task automatic issue_long(input logic [4:0] d);
    logic st;
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, d, 1'b1, 1'b0, 1'b0, 5'd0, st);
  endtask

  task automatic retire(input logic [4:0] r);
    logic st;
    step(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, r, st);
  endtask

  initial begin
    logic st;
    logic [2:0] saved_cnt;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_pending", pend, 32'd0);
    check_val("reset_outstanding", {29'd0, outst}, 32'd0);
    check_val("reset_err", {31'd0, err}, 32'd0);
    check_val("reset_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // limit of two: WAW on rd3, then a full stall on rd6
    @(negedge clk); b_iv = 1'b1; b_lng = 1'b1; b_rd = 5'd3; #1;
    check_val("b_first", {31'd0, b_stall}, 32'd0);
    @(negedge clk); b_rd = 5'd3; #1;
    check_val("b_waw", {31'd0, b_stall}, 32'd1);
    @(negedge clk); b_rd = 5'd4; #1;
    check_val("b_second", {31'd0, b_stall}, 32'd0);
    @(negedge clk); b_rd = 5'd6; #1;
    check_val("b_full", {31'd0, b_stall}, 32'd1);
    check_val("b_full_cnt", {29'd0, b_outst}, 32'd2);
    @(negedge clk); b_iv = 1'b0; #1;
    check_val("b_pending", b_pend, 32'h0000_0018);

    // load-use on x5 stalls until the writeback cycle itself
    issue_long(5'd5);
    step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 5'd0, st);
    check_val("load_use_stall", {31'd0, st}, 32'd1);
    step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 5'd0, st);
    check_val("load_use_hold", {31'd0, st}, 32'd1);
    step(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 5'd5, st);
    check_val("load_use_release", {31'd0, st}, 32'd0);

    // same-cycle retire and re-issue of x7 keeps the bit and the count
    issue_long(5'd7);
    saved_cnt = outst;
    step(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, st);
    check_val("setclr_accept", {31'd0, st}, 32'd0);
    check_val("setclr_bit", {31'd0, pend[7]}, 32'd1);
    check_val("setclr_cnt", {29'd0, outst}, {29'd0, saved_cnt});
    retire(5'd7);

    // x0 is never tracked and never blocks
    issue_long(5'd0);
    check_val("x0_pending", pend, 32'd0);
    check_val("x0_cnt", {29'd0, outst}, 32'd0);
    step(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, st);
    check_val("x0_stall", {31'd0, st}, 32'd0);

    // flush masks a live hazard and leaves the state alone
    issue_long(5'd12);
    step(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0, 5'd0, st);
    check_val("flush_stall", {31'd0, st}, 32'd0);
    check_val("flush_pending", pend, 32'h0000_1000);
    retire(5'd12);

    // randomized traffic over a small register window to force collisions
    for (int n = 0; n < 400; n++) begin
      bit v, a1, a2, lo, f, wv;
      logic [4:0] s1, s2, d, wr;
      v  = ($urandom % 4) != 0;
      a1 = $urandom % 2; a2 = $urandom % 2;
      s1 = 5'($urandom % 8); s2 = 5'($urandom % 8); d = 5'($urandom % 8);
      lo = ($urandom % 3) != 0;
      f  = ($urandom % 8) == 0;
      wv = 1'b0; wr = 5'd0;
      if (m_count() != 0 && ($urandom % 3) == 0) begin
        int start = $urandom % 32;
        for (int k = 0; k < 32; k++) begin
          if (!wv && m_pend[(start + k) % 32]) begin
            wv = 1'b1;
            wr = 5'((start + k) % 32);
          end
        end
      end
      step(v, s1, a1, s2, a2, d, lo, f, wv, wr, st);
    end
    for (int k = 1; k < 32; k++) if (m_pend[k]) retire(5'(k));

    // spurious writeback raises the sticky error; reset then clears it
    retire(5'd9);
    check_val("err_set", {31'd0, err}, 32'd1);
    idle();
    check_val("err_held", {31'd0, err}, 32'd1);

    // asynchronous reset in the middle of a cycle with three writes in flight
    issue_long(5'd10);
    issue_long(5'd11);
    issue_long(5'd13);
    check_val("pre_rst_cnt", {29'd0, outst}, 32'd3);
    @(negedge clk);
    iv = 1'b0; lng = 1'b0; wbv = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_val("async_pending", pend, 32'd0);
    check_val("async_cnt", {29'd0, outst}, 32'd0);
    check_val("async_err", {31'd0, err}, 32'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    retire(5'd10);
    check_val("stale_wb_err", {31'd0, err}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
